// File: rtl/button_pkg.sv
// button_pkg: state encoding and counter width shared by the button event decoder.
package button_pkg;
  localparam int CNT_W = 32;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HELD1     = 3'd1,
    LONG_HELD = 3'd2,
    WAIT2     = 3'd3,
    HELD2     = 3'd4
  } state_t;
endpackage

// File: rtl/button_event_decoder_if.sv
// button_event_decoder_if: debounced switch level in, press-class pulses out.
interface button_event_decoder_if;
  logic sw_in;
  logic pressed;
  logic short_press;
  logic long_press;
  logic double_press;
  logic busy;
  modport master (output sw_in, input pressed, short_press, long_press, double_press, busy);
  modport slave (input sw_in, output pressed, short_press, long_press, double_press, busy);
endinterface

// File: rtl/button_edge_detect.sv
// button_edge_detect: polarity-corrected pressed register with press/release edges.
module button_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic sw_in,
  output logic pressed,
  output logic rise,
  output logic fall
);
  logic pressed_d, pressed_q;
  assign pressed_d = sw_in ^ ACTIVE_LOW;
  // Loads every cycle, reset included, so a button held through reset yields no edge.
  always_ff @(posedge clk) pressed_q <= pressed_d;
  assign pressed = pressed_q;
  assign rise = pressed_d & ~pressed_q;
  assign fall = ~pressed_d & pressed_q;
endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies debounced presses as short, long or double pulses.
module button_event_decoder
  import button_pkg::*;
#(
  parameter logic [CNT_W-1:0] LONG_TICKS   = 32'd50_000_000,
  parameter logic [CNT_W-1:0] DOUBLE_TICKS = 32'd12_500_000,
  parameter bit               ACTIVE_LOW   = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  button_event_decoder_if.slave bus
);
  logic rise, fall;
  state_t state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic short_d, short_q, long_d, long_q, double_d, double_q, busy_q;
  button_edge_detect #(.ACTIVE_LOW(ACTIVE_LOW)) u_edge (
    .clk    (clk),
    .sw_in  (bus.sw_in),
    .pressed(bus.pressed),
    .rise   (rise),
    .fall   (fall)
  );
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        state_d = HELD1;
        cnt_d   = LONG_TICKS;
      end
      HELD1: if (fall) begin
        state_d = WAIT2;
        cnt_d   = DOUBLE_TICKS;
      end else if (cnt_q == '0) begin
        state_d = LONG_HELD;
        long_d  = 1'b1;
      end
      LONG_HELD: if (fall) state_d = IDLE;
      WAIT2: if (rise) begin
        state_d = HELD2;
        cnt_d   = LONG_TICKS;
      end else if (cnt_q == '0) begin
        state_d = IDLE;
        short_d = 1'b1;
      end
      HELD2: if (fall) begin
        state_d  = IDLE;
        double_d = 1'b1;
      end else if (cnt_q == '0) begin
        state_d = LONG_HELD;
        long_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= state_d != IDLE;
    end
  end
  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_press = double_q;
  assign bus.busy         = busy_q;
endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
Sits directly downstream of the switch debouncer and consumes its clean, debounced level. Classifies each press of a front-panel button as short, long or double, and emits a one-cycle pulse for each class. The pulses go to the monitor's power-sequencing and control logic. The block does no debouncing of its own: its input must already be glitch-free.

Parameters:
LONG_TICKS, 32'd50_000_000, clocks a press must be held before it counts as long; must be >= 1
DOUBLE_TICKS, 32'd12_500_000, clocks after a release in which a second press makes a double press; must be >= 1
ACTIVE_LOW, 1, 1: button pressed when sw_in=0; 0: pressed when sw_in=1

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
sw_in  input  1  debounced switch level from the debouncer
pressed  output  1  registered, polarity-corrected button level
short_press  output  1  one-cycle pulse: single short press completed
long_press  output  1  one-cycle pulse: hold reached LONG_TICKS
double_press  output  1  one-cycle pulse: second press released
busy  output  1  high whenever state != IDLE

Behaviour:
- Level: p = sw_in XOR ACTIVE_LOW.
  - The pressed register updates from p every cycle.
  - Press edge: p=1 and pressed=0. Release edge: p=0 and pressed=1.
- Reset:
  - state=IDLE, counter=0, all pulses=0, busy=0.
  - pressed loads p, so a button already held during reset generates no edge.
- Counter: 32-bit, unsigned. Each cycle it decrements by 1 when nonzero, except in a cycle where it is loaded. It never wraps below 0.
- States:
  - IDLE: press edge -> HELD1, counter<=LONG_TICKS.
  - HELD1:
    - Release edge -> WAIT2, counter<=DOUBLE_TICKS.
    - Else if counter==0 -> long_press<=1, go to LONG_HELD.
    - Release takes priority over timeout in the same cycle.
  - LONG_HELD: release edge -> IDLE. No further pulses, no auto-repeat.
  - WAIT2:
    - Press edge -> HELD2, counter<=LONG_TICKS.
    - Else if counter==0 -> short_press<=1, go to IDLE.
    - Press takes priority over timeout.
  - HELD2:
    - Release edge -> double_press<=1, go to IDLE.
    - Else if counter==0 -> long_press<=1, go to LONG_HELD. The pending double press is discarded.
- Latency: taking edge E as the clock edge that moves IDLE->HELD1 (or WAIT2->HELD2):
  - long_press goes high in the cycle after edge E+LONG_TICKS+1.
  - short_press goes high in the cycle after the release edge + DOUBLE_TICKS+1.
  - double_press goes high in the cycle after the second release edge.
- Pulses:
  - Registered and exactly one cycle wide.
  - At most one pulse asserts in any cycle.
  - Every press sequence ends in exactly one pulse.
- busy: registered. High from the cycle after leaving IDLE until the cycle after returning to IDLE.
- Reset mid-operation: immediate return to IDLE. Any pending pulse is suppressed; pulses are 0 in the cycle after the reset edge.

Decomposition:
- Shared package button_pkg holds:
  - state encoding constants: IDLE, HELD1, LONG_HELD, WAIT2, HELD2 (3 bits);
  - counter width constant CNT_W=32.
- One sub-module, button_edge_detect. It holds the pressed register and the polarity XOR, and outputs pressed, rise and fall.

Test Plan:
All scenarios use LONG_TICKS=10, DOUBLE_TICKS=5, ACTIVE_LOW=0.
1. Press for 4 clocks, release, stay idle -> one short_press pulse 6 clocks after the release edge; no other pulses; busy returns to 0.
2. Hold for 20 clocks -> long_press pulse 11 clocks after the press edge; release -> no pulse; state IDLE.
3. Press 3, release 2, press 3, release -> double_press on the cycle after the second release; short_press never asserts.
4. Release 3 clocks after the press while the WAIT2 counter is 0 on the same edge as a new press -> HELD2 is entered (press wins); the later release gives double_press.
5. Hold sw_in=1 through reset and deassert rst -> no pulses; busy=0; the release after reset produces no pulse.
6. Assert rst during WAIT2 -> no short_press; all outputs 0 on the cycle after the reset edge.
